alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter ALU_LATENCY, default 1, cycles from ALU operand sampling edge to valid Alu_Out (range 1..4).
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req_Valid  input  2  per-lane request valid (lane 0 = bit 0).
REQ-005 Req_Ready  output  2  per-lane request accept; at most one bit high per cycle.
REQ-006 Req_A  input  16  lane i operand A in bits [8i+7:8i].
REQ-007 Req_B  input  16  lane i operand B in bits [8i+7:8i].
REQ-008 Req_Sel  input  8  lane i opcode in bits [4i+3:4i]; ALU opcode encoding 0000 add .. 0110 xor.
REQ-009 Rsp_Valid  output  2  per-lane response valid; at most one bit high.
REQ-010 Rsp_Ready  input  2  per-lane response accept.
REQ-011 Rsp_Data  output  8  result for lane flagged by Rsp_Valid.
REQ-012 Rsp_Carry  output  1  carry for add; 0 for every other opcode.
REQ-013 Rsp_Err  output  1  illegal opcode or divide-by-zero.
REQ-014 Alu_A, Alu_B  output  8 each  operands to shared ALU.
REQ-015 Alu_Sel  output  4  opcode to shared ALU.
REQ-016 Alu_Out  input  8  ALU result; Alu_Carry  input  1  ALU carry.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-018 IDLE: if any Req_Valid, grant one lane by round-robin; Req_Ready[g]=1 combinationally that cycle only; capture A, B, Sel, lane id on that edge.
REQ-019 Round-robin: lane not granted last wins when both valid; after reset lane 0 has priority.
REQ-020 Req_Ready SHALL be 0 in ISSUE, WAIT, RESP.
REQ-021 Captured legal op -> ISSUE; Sel in 0111..1111, or Sel=0011 with B=0 -> RESP directly, Rsp_Data=0, Rsp_Carry=0, Rsp_Err=1, ALU not issued.
REQ-022 Alu_A/Alu_B/Alu_Sel driven from capture registers, stable from ISSUE through WAIT; hold last value otherwise.
REQ-023 ISSUE lasts exactly 1 cycle, then WAIT.
REQ-024 WAIT lasts exactly ALU_LATENCY cycles (down-counter); on last WAIT edge capture Alu_Out into Rsp_Data, Alu_Carry into Rsp_Carry only if Sel=0000 else 0; Rsp_Err=0; go RESP.
REQ-025 Latency (L=ALU_LATENCY): request accepted cycle 0 -> Rsp_Valid high from cycle 2+L.
REQ-026 RESP: Rsp_Valid[lane]=1, Rsp_Data/Carry/Err stable until Rsp_Ready[lane]=1; on that edge -> IDLE.
REQ-027 Rsp_Ready on the non-owning lane SHALL be ignored.
REQ-028 New grant not possible in the RESP-exit cycle; earliest next Req_Ready is the cycle after handshake.
REQ-029 Req_Valid deassert without handshake SHALL have no effect; no request queuing beyond the one in flight.

Reset
REQ-030 Reset SHALL force IDLE, round-robin pointer to lane-0 priority, WAIT counter 0.
REQ-031 Reset values: Req_Ready=0, Rsp_Valid=0, Rsp_Data=0, Rsp_Carry=0, Rsp_Err=0, Alu_A=0, Alu_B=0, Alu_Sel=0.
REQ-032 Reset in any state SHALL drop the in-flight transaction with no response; late Alu_Out ignored.

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode constants (OP_ADD..OP_XOR), the FSM state enum, and data width 8.
REQ-034 Round-robin grant logic SHALL be sub-module rr_arb2 (inputs request[1:0], last-grant pointer; output one-hot grant).
REQ-035 Block SHALL NOT instantiate the ALU; the bench connects the ALU externally.

Verification
REQ-036 Lane 0 add A=0xF0 B=0x20, Rsp_Ready=1 -> Rsp_Valid[0] at cycle 3 (L=1), Data=0x10, Carry=1, Err=0.
REQ-037 Both lanes valid continuously, lane0 sub 0x05-0x07, lane1 and 0x3C&0x0F -> grants 0,1,0,1; Data 0xFE (Carry=0) then 0x0C.
REQ-038 Lane 1 div A=0x09 B=0x00 -> no ALU issue, Rsp_Valid[1] cycle 1, Data=0, Err=1; opcode 1010 same result.
REQ-039 Lane 0 mul 0x10*0x11, Rsp_Ready low 5 cycles -> Rsp_Valid/Data=0x10 held stable, Req_Ready stays 0 on both lanes.
REQ-040 Reset asserted in WAIT -> next cycle all outputs 0, IDLE; subsequent lane 1 request granted with lane-0 priority restored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-lane ALU request scheduler: data width,
// opcode encoding and scheduler FSM states.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requests that never reach the ALU: unknown opcodes and divide-by-zero.
  function automatic logic is_illegal(input logic [3:0] sel, input logic [DATA_W-1:0] b);
    return (sel > OP_XOR) || ((sel == OP_DIV) && (b == '0));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the lane not granted last wins.
module rr_arb2 (
  input  logic [1:0] request,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (request == 2'b11) grant = last ? 2'b01 : 2'b10;
    else                  grant = request;
  end

endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two request lanes onto one external ALU, one transaction in flight,
// and returns each result on the owning lane's response handshake.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            Req_Valid,
  output logic [1:0]            Req_Ready,
  input  logic [2*DATA_W-1:0]   Req_A,
  input  logic [2*DATA_W-1:0]   Req_B,
  input  logic [7:0]            Req_Sel,
  output logic [1:0]            Rsp_Valid,
  input  logic [1:0]            Rsp_Ready,
  output logic [DATA_W-1:0]     Rsp_Data,
  output logic                  Rsp_Carry,
  output logic                  Rsp_Err,
  output logic [DATA_W-1:0]     Alu_A,
  output logic [DATA_W-1:0]     Alu_B,
  output logic [3:0]            Alu_Sel,
  input  logic [DATA_W-1:0]     Alu_Out,
  input  logic                  Alu_Carry,
  output logic [1:0]            Fsm_State
);

  // Handshakes: a request transfers on a cycle where Req_Valid[i] and
  // Req_Ready[i] are both high; a response transfers on a cycle where
  // Rsp_Valid[i] and Rsp_Ready[i] are both high. Ready never depends on
  // anything but the FSM state and the arbiter.

  state_t              state;
  logic                last_q;
  logic                lane_q;
  logic [1:0]          cnt_q;
  logic [1:0]          grant;
  logic                gnt_lane;
  logic [DATA_W-1:0]   g_a;
  logic [DATA_W-1:0]   g_b;
  logic [3:0]          g_sel;

  rr_arb2 u_arb (
    .request (Req_Valid),
    .last    (last_q),
    .grant   (grant)
  );

  assign gnt_lane  = grant[1];
  assign g_a       = gnt_lane ? Req_A[2*DATA_W-1:DATA_W] : Req_A[DATA_W-1:0];
  assign g_b       = gnt_lane ? Req_B[2*DATA_W-1:DATA_W] : Req_B[DATA_W-1:0];
  assign g_sel     = gnt_lane ? Req_Sel[7:4] : Req_Sel[3:0];

  assign Req_Ready = ((state == IDLE) && !Reset) ? grant : 2'b00;
  assign Rsp_Valid = (state == RESP) ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
  assign Fsm_State = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      last_q    <= 1'b1;
      lane_q    <= 1'b0;
      cnt_q     <= 2'd0;
      Rsp_Data  <= '0;
      Rsp_Carry <= 1'b0;
      Rsp_Err   <= 1'b0;
      Alu_A     <= '0;
      Alu_B     <= '0;
      Alu_Sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            last_q <= gnt_lane;
            lane_q <= gnt_lane;
            // Rejected requests leave the ALU operands untouched.
            if (is_illegal(g_sel, g_b)) begin
              Rsp_Data  <= '0;
              Rsp_Carry <= 1'b0;
              Rsp_Err   <= 1'b1;
              state     <= RESP;
            end else begin
              Alu_A   <= g_a;
              Alu_B   <= g_b;
              Alu_Sel <= g_sel;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q <= 2'(ALU_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            Rsp_Data  <= Alu_Out;
            Rsp_Carry <= (Alu_Sel == OP_ADD) && Alu_Carry;
            Rsp_Err   <= 1'b0;
            state     <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (Rsp_Ready[lane_q]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with an external pipelined ALU model.
module tb_alu_scheduler;
  import alu_pkg::*;

  localparam int L = 1;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Req_Valid = '0;
  logic [1:0]  Req_Ready;
  logic [15:0] Req_A = '0;
  logic [15:0] Req_B = '0;
  logic [7:0]  Req_Sel = '0;
  logic [1:0]  Rsp_Valid;
  logic [1:0]  Rsp_Ready = '0;
  logic [7:0]  Rsp_Data;
  logic        Rsp_Carry;
  logic        Rsp_Err;
  logic [7:0]  Alu_A;
  logic [7:0]  Alu_B;
  logic [3:0]  Alu_Sel;
  logic [7:0]  Alu_Out;
  logic        Alu_Carry;
  logic [1:0]  Fsm_State;

  int n_checks = 0;
  int n_errors = 0;

  alu_scheduler #(.ALU_LATENCY(L)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_A     (Req_A),
    .Req_B     (Req_B),
    .Req_Sel   (Req_Sel),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Ready (Rsp_Ready),
    .Rsp_Data  (Rsp_Data),
    .Rsp_Carry (Rsp_Carry),
    .Rsp_Err   (Rsp_Err),
    .Alu_A     (Alu_A),
    .Alu_B     (Alu_B),
    .Alu_Sel   (Alu_Sel),
    .Alu_Out   (Alu_Out),
    .Alu_Carry (Alu_Carry),
    .Fsm_State (Fsm_State)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // external ALU model: L register stages, carry in bit 8
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (s)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return p[8:0];
      4'd3:    return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, a | b};
      4'd6:    return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] alu_pipe [L];
  always @(posedge Clock) begin
    alu_pipe[0] <= alu_f(Alu_A, Alu_B, Alu_Sel);
    for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign Alu_Out   = alu_pipe[L-1][7:0];
  assign Alu_Carry = alu_pipe[L-1][8];

  // checking
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int lane);
    return (lane != 0) ? 2'b10 : 2'b01;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    Req_A[lane*8 +: 8]   = a;
    Req_B[lane*8 +: 8]   = b;
    Req_Sel[lane*4 +: 4] = sel;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 16'(Req_Ready), 16'h0);
    check({tag, "_rsp_valid"}, 16'(Rsp_Valid), 16'h0);
    check({tag, "_rsp_data"},  16'(Rsp_Data),  16'h0);
    check({tag, "_rsp_carry"}, 16'(Rsp_Carry), 16'h0);
    check({tag, "_rsp_err"},   16'(Rsp_Err),   16'h0);
    check({tag, "_alu_a"},     16'(Alu_A),     16'h0);
    check({tag, "_alu_b"},     16'(Alu_B),     16'h0);
    check({tag, "_alu_sel"},   16'(Alu_Sel),   16'h0);
    check({tag, "_state"},     16'(Fsm_State), 16'(IDLE));
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    Req_Valid = '0;
    Rsp_Ready = '0;
    tick();
    tick();
    check_zero("reset");
    Reset = 1'b0;
    tick();
  endtask

  // inputs already set this cycle; check the grant, then cross the edge
  task automatic grant_step(input string tag, input logic [1:0] exp_gnt);
    #1;
    check({tag, "_gnt"}, 16'(Req_Ready), 16'(exp_gnt));
    tick();
  endtask

  // called in cycle 1 after acceptance; lat is the cycle index of first Rsp_Valid
  task automatic rsp_step(input string tag, input int lane, input int lat, input logic [7:0] data,
                          input logic carry, input logic err, input logic ack);
    int n = 1;
    while (Rsp_Valid == 2'b00 && n < 16) begin
      tick();
      n++;
    end
    check({tag, "_lat"},       16'(n),         16'(lat));
    check({tag, "_valid"},     16'(Rsp_Valid), 16'(oh(lane)));
    check({tag, "_data"},      16'(Rsp_Data),  16'(data));
    check({tag, "_carry"},     16'(Rsp_Carry), 16'(carry));
    check({tag, "_err"},       16'(Rsp_Err),   16'(err));
    check({tag, "_req_ready"}, 16'(Req_Ready), 16'h0);
    if (ack) begin
      Rsp_Ready = oh(lane);
      tick();
      Rsp_Ready = 2'b00;
      check({tag, "_idle"},    16'(Fsm_State), 16'(IDLE));
      check({tag, "_dropped"}, 16'(Rsp_Valid), 16'h0);
    end
  endtask

  task automatic run_one(input string tag, input int lane, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [7:0] data, input logic carry, input logic err);
    set_lane(lane, a, b, sel);
    Req_Valid = oh(lane);
    grant_step(tag, oh(lane));
    Req_Valid = 2'b00;
    rsp_step(tag, lane, err ? 1 : 2 + L, data, carry, err, 1'b1);
  endtask

  // scenarios
  initial begin
    do_reset();

    // lane 0 add with carry out
    set_lane(0, 8'hF0, 8'h20, OP_ADD);
    Req_Valid = 2'b01;
    grant_step("add", 2'b01);
    Req_Valid = 2'b00;
    check("add_issue_state", 16'(Fsm_State), 16'(ISSUE));
    check("add_alu_a",       16'(Alu_A),     16'h00F0);
    check("add_alu_b",       16'(Alu_B),     16'h0020);
    check("add_alu_sel",     16'(Alu_Sel),   16'(OP_ADD));
    rsp_step("add", 0, 2 + L, 8'h10, 1'b1, 1'b0, 1'b1);

    // both lanes held valid: strict alternation starting at lane 0
    do_reset();
    set_lane(0, 8'h05, 8'h07, OP_SUB);
    set_lane(1, 8'h3C, 8'h0F, OP_AND);
    Req_Valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      grant_step("rr", oh(k % 2));
      rsp_step("rr", k % 2, 2 + L, (k % 2 != 0) ? 8'h0C : 8'hFE, 1'b0, 1'b0, 1'b1);
    end
    Req_Valid = 2'b00;

    // rejected requests bypass the ALU and keep its operands
    set_lane(1, 8'h09, 8'h00, OP_DIV);
    Req_Valid = 2'b10;
    grant_step("div0", 2'b10);
    Req_Valid = 2'b00;
    check("div0_alu_a",   16'(Alu_A),   16'h003C);
    check("div0_alu_b",   16'(Alu_B),   16'h000F);
    check("div0_alu_sel", 16'(Alu_Sel), 16'(OP_AND));
    rsp_step("div0", 1, 1, 8'h00, 1'b0, 1'b1, 1'b1);
    run_one("op1010", 1, 8'h09, 8'h05, 4'b1010, 8'h00, 1'b0, 1'b1);
    run_one("op1111", 0, 8'h12, 8'h34, 4'b1111, 8'h00, 1'b0, 1'b1);

    // assorted legal ops
    run_one("or",   1, 8'hA0, 8'h05, OP_OR,  8'hA5, 1'b0, 1'b0);
    run_one("xor",  0, 8'hFF, 8'h0F, OP_XOR, 8'hF0, 1'b0, 1'b0);
    run_one("div",  0, 8'h40, 8'h04, OP_DIV, 8'h10, 1'b0, 1'b0);
    run_one("add2", 1, 8'h01, 8'h02, OP_ADD, 8'h03, 1'b0, 1'b0);

    // response back-pressure, foreign Rsp_Ready ignored, no new grant
    set_lane(0, 8'h10, 8'h11, OP_MUL);
    set_lane(1, 8'h01, 8'h01, OP_ADD);
    Req_Valid = 2'b01;
    grant_step("mul", 2'b01);
    Req_Valid = 2'b11;
    rsp_step("mul", 0, 2 + L, 8'h10, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      Rsp_Ready = 2'b10;
      tick();
      check("hold_valid",     16'(Rsp_Valid), 16'h0001);
      check("hold_data",      16'(Rsp_Data),  16'h0010);
      check("hold_carry",     16'(Rsp_Carry), 16'h0000);
      check("hold_req_ready", 16'(Req_Ready), 16'h0000);
    end
    Req_Valid = 2'b00;
    Rsp_Ready = 2'b01;
    tick();
    Rsp_Ready = 2'b00;
    check("hold_release_valid", 16'(Rsp_Valid), 16'h0);
    check("hold_release_state", 16'(Fsm_State), 16'(IDLE));

    // reset mid-flight: transaction dropped, lane-0 priority restored
    set_lane(0, 8'h01, 8'h01, OP_ADD);
    Req_Valid = 2'b01;
    grant_step("rst", 2'b01);
    Req_Valid = 2'b00;
    tick();
    check("rst_wait_state", 16'(Fsm_State), 16'(WAIT));
    Reset = 1'b1;
    tick();
    check_zero("rst_wait");
    Reset = 1'b0;
    tick();
    tick();
    check("rst_no_rsp",   16'(Rsp_Valid), 16'h0);
    check("rst_idle",     16'(Fsm_State), 16'(IDLE));
    set_lane(0, 8'h22, 8'h11, OP_SUB);
    set_lane(1, 8'h05, 8'h03, OP_MUL);
    Req_Valid = 2'b11;
    grant_step("rst_pri", 2'b01);
    Req_Valid = 2'b00;
    rsp_step("rst_pri", 0, 2 + L, 8'h11, 1'b0, 1'b0, 1'b1);
    run_one("rst_l1", 1, 8'h05, 8'h03, OP_MUL, 8'h0F, 1'b0, 1'b0);

    // report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
